// File: rtl/piradip_util_pkg.sv
// -----------------------------------------------------------------------------
// piradip_util_pkg
//   Width helpers shared by the latency credit FIFO and the sideband
//   synchronizer. The package holds only functions, so every user derives its
//   own widths from its own parameters.
//     clog2p1(n)   : bits needed to hold a count in the range 0..n
//     ptr_width(d) : bits needed to index d entries (at least 1)
//     max1(n)      : n, but never less than 1 (for optional fields)
// -----------------------------------------------------------------------------
package piradip_util_pkg;

    function automatic int clog2p1(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int max1(input int n);
        return (n > 1) ? n : 1;
    endfunction

endpackage

// File: rtl/piradip_fifo_core.sv
// -----------------------------------------------------------------------------
// piradip_fifo_core
//   First-word-fall-through FIFO: register array, wrapping pointers and an
//   occupancy count. DEPTH need not be a power of two. The caller must only
//   push when not full (or when popping in the same cycle) and only pop when
//   not empty.
//   Ports:
//     aclk, aresetn  clock, asynchronous active-low reset
//     i_push/i_wdata write i_wdata into the tail entry
//     i_pop          drop the head entry
//     o_rdata        head entry, read combinationally
//     o_occupancy    entries currently stored (0..DEPTH)
//     o_full/o_empty occupancy == DEPTH / occupancy == 0
// -----------------------------------------------------------------------------
module piradip_fifo_core
    import piradip_util_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        i_push,
    input  logic [WIDTH-1:0]            i_wdata,
    input  logic                        i_pop,
    output logic [WIDTH-1:0]            o_rdata,
    output logic [clog2p1(DEPTH)-1:0]   o_occupancy,
    output logic                        o_full,
    output logic                        o_empty
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = clog2p1(DEPTH);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // NOTE: the storage array deliberately has no reset; only the pointers and
    // the count decide what is valid, and leaving the array out of the reset
    // lets it map onto plain flops or RAM without a reset tree.
    always_ff @(posedge aclk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Explicit wrap so non-power-of-two depths work.
            if (i_push) begin
                r_wr_ptr <= (r_wr_ptr == LAST_IDX) ? '0 : r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_IDX) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata     = r_mem[r_rd_ptr];
    assign o_occupancy = r_count;
    assign o_full      = (r_count == CNT_W'(DEPTH));
    assign o_empty     = (r_count == '0);

endmodule

// File: rtl/piradip_latency_credit_fifo.sv
// -----------------------------------------------------------------------------
// piradip_latency_credit_fifo
//   Sink stage behind a fixed-latency, non-stalling pipeline. Every sample
//   issued into the pipeline reserves a FIFO slot (a credit), so the word that
//   arrives DATA_LATENCY cycles later always has room. Output is AXI-Stream.
//   Ports:
//     aclk, aresetn          clock, asynchronous active-low reset
//     issue_valid/ready      upstream issue handshake (ready = credit free)
//     arr_valid/arr_data     delayed {oob, in_band} word from the pipeline
//     m_tvalid/tready        AXI-Stream handshake
//     m_tdata, m_tuser       in-band and out-of-band parts of the head word
//     occupancy              words stored
//     reserved               credits in use (stored + in flight)
//     overflow               sticky: arrival while full, word dropped
//     orphan                 sticky: arrival with no in-flight credit
// -----------------------------------------------------------------------------
module piradip_latency_credit_fifo
    import piradip_util_pkg::*;
#(
    parameter int IN_BAND_WIDTH     = 32,
    parameter int OUT_OF_BAND_WIDTH = 1,
    parameter int DATA_LATENCY      = 1,
    parameter int DEPTH             = 8
) (
    input  logic                                        aclk,
    input  logic                                        aresetn,
    input  logic                                        issue_valid,
    output logic                                        issue_ready,
    input  logic                                        arr_valid,
    input  logic [IN_BAND_WIDTH+OUT_OF_BAND_WIDTH-1:0]  arr_data,
    output logic                                        m_tvalid,
    input  logic                                        m_tready,
    output logic [IN_BAND_WIDTH-1:0]                    m_tdata,
    output logic [max1(OUT_OF_BAND_WIDTH)-1:0]          m_tuser,
    output logic [clog2p1(DEPTH)-1:0]                   occupancy,
    output logic [clog2p1(DEPTH)-1:0]                   reserved,
    output logic                                        overflow,
    output logic                                        orphan
);

    localparam int DATA_W = IN_BAND_WIDTH + OUT_OF_BAND_WIDTH;
    localparam int CNT_W  = clog2p1(DEPTH);

    if (DEPTH < DATA_LATENCY + 1) begin : g_depth_check
        $error("piradip_latency_credit_fifo: DEPTH must be >= DATA_LATENCY+1");
    end

    logic [DATA_W-1:0] w_rdata;
    logic [CNT_W-1:0]  w_occupancy;
    logic [CNT_W-1:0]  w_inflight;
    logic              w_full;
    logic              w_empty;
    logic              w_fire;
    logic              w_pop;
    logic              w_push;
    logic [CNT_W-1:0]  r_reserved;
    logic              r_overflow;
    logic              r_orphan;

    assign w_fire     = issue_valid & issue_ready;
    assign w_pop      = ~w_empty & m_tready;
    // Push is judged against the pre-pop count, so a full FIFO that is
    // popping this cycle still accepts the arriving word.
    assign w_push     = arr_valid & (~w_full | w_pop);
    assign w_inflight = r_reserved - w_occupancy;

    piradip_fifo_core #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_core (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .i_push      (w_push),
        .i_wdata     (arr_data),
        .i_pop       (w_pop),
        .o_rdata     (w_rdata),
        .o_occupancy (w_occupancy),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_reserved <= '0;
            r_overflow <= 1'b0;
            r_orphan   <= 1'b0;
        end else begin
            // A pop frees its credit for the next cycle: issue_ready only
            // looks at the registered count, never at m_tready.
            case ({w_fire, w_pop})
                2'b10: r_reserved <= r_reserved + 1'b1;
                // An orphan word was stored without a credit; popping it must
                // not drive the credit count below zero.
                2'b01: r_reserved <= (r_reserved != '0) ? r_reserved - 1'b1 : r_reserved;
                default: r_reserved <= r_reserved;
            endcase
            if (arr_valid && (w_inflight == '0)) begin
                r_orphan <= 1'b1;
            end
            if (arr_valid && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign issue_ready = (r_reserved < CNT_W'(DEPTH));
    assign m_tvalid    = ~w_empty;
    assign m_tdata     = w_rdata[IN_BAND_WIDTH-1:0];
    assign occupancy   = w_occupancy;
    assign reserved    = r_reserved;
    assign overflow    = r_overflow;
    assign orphan      = r_orphan;

    if (OUT_OF_BAND_WIDTH > 0) begin : g_oob
        assign m_tuser = w_rdata[DATA_W-1:IN_BAND_WIDTH];
    end else begin : g_no_oob
        assign m_tuser = '0;
    end

endmodule

// File: tb/tb_piradip_latency_credit_fifo.sv
// -----------------------------------------------------------------------------
// tb_piradip_latency_credit_fifo
//   Two instances: A (32+1 bits, latency 3, depth 4) and B (8+0 bits,
//   latency 1, depth 5). A small upstream model per instance delays issued
//   words by the latency and pushes each expected word into a scoreboard
//   queue; a monitor pops and compares on every AXI-Stream transfer.
// -----------------------------------------------------------------------------
module tb_piradip_latency_credit_fifo;

    localparam int A_IN = 32, A_OOB = 1, A_LAT = 3, A_DEPTH = 4;
    localparam int B_IN = 8,  B_OOB = 0, B_LAT = 1, B_DEPTH = 5;
    localparam int A_W  = A_IN + A_OOB;
    localparam int B_W  = B_IN + B_OOB;
    localparam int A_CW = $clog2(A_DEPTH + 1);
    localparam int B_CW = $clog2(B_DEPTH + 1);

    logic clk;
    logic aresetn;

    logic             a_issue_valid, a_issue_ready, a_arr_valid, a_tvalid, a_tready;
    logic [A_W-1:0]   a_arr_data;
    logic [A_IN-1:0]  a_tdata;
    logic [0:0]       a_tuser;
    logic [A_CW-1:0]  a_occ, a_res;
    logic             a_ovf, a_orph;

    logic             b_issue_valid, b_issue_ready, b_arr_valid, b_tvalid, b_tready;
    logic [B_W-1:0]   b_arr_data;
    logic [B_IN-1:0]  b_tdata;
    logic [0:0]       b_tuser;
    logic [B_CW-1:0]  b_occ, b_res;
    logic             b_ovf, b_orph;

    // Upstream pipeline models and forced-arrival controls
    logic [2:0]       a_pipe_v;
    logic [A_W-1:0]   a_pipe_d [3];
    logic             a_force_v, a_force_exp;
    logic [A_W-1:0]   a_force_d;
    logic [A_W-1:0]   a_word;
    logic             a_fire;
    int               a_seq, a_fires;
    logic [A_W-1:0]   a_exp_q[$];

    logic             b_pipe_v;
    logic [B_W-1:0]   b_pipe_d;
    logic             b_force_v, b_force_exp;
    logic [B_W-1:0]   b_force_d;
    logic [B_W-1:0]   b_word;
    logic             b_fire;
    int               b_seq, b_fires;
    logic [B_W-1:0]   b_exp_q[$];

    int               n_checks;
    int               n_fail;
    logic             stim_done;

    piradip_latency_credit_fifo #(
        .IN_BAND_WIDTH(A_IN), .OUT_OF_BAND_WIDTH(A_OOB), .DATA_LATENCY(A_LAT), .DEPTH(A_DEPTH)
    ) u_dut_a (
        .aclk(clk), .aresetn(aresetn),
        .issue_valid(a_issue_valid), .issue_ready(a_issue_ready),
        .arr_valid(a_arr_valid), .arr_data(a_arr_data),
        .m_tvalid(a_tvalid), .m_tready(a_tready), .m_tdata(a_tdata), .m_tuser(a_tuser),
        .occupancy(a_occ), .reserved(a_res), .overflow(a_ovf), .orphan(a_orph)
    );

    piradip_latency_credit_fifo #(
        .IN_BAND_WIDTH(B_IN), .OUT_OF_BAND_WIDTH(B_OOB), .DATA_LATENCY(B_LAT), .DEPTH(B_DEPTH)
    ) u_dut_b (
        .aclk(clk), .aresetn(aresetn),
        .issue_valid(b_issue_valid), .issue_ready(b_issue_ready),
        .arr_valid(b_arr_valid), .arr_data(b_arr_data),
        .m_tvalid(b_tvalid), .m_tready(b_tready), .m_tdata(b_tdata), .m_tuser(b_tuser),
        .occupancy(b_occ), .reserved(b_res), .overflow(b_ovf), .orphan(b_orph)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign a_fire      = a_issue_valid & a_issue_ready;
    assign a_word      = {a_seq[0], A_IN'(32'hA000_0000 + a_seq)};
    assign a_arr_valid = a_pipe_v[2] | a_force_v;
    assign a_arr_data  = a_force_v ? a_force_d : a_pipe_d[2];

    assign b_fire      = b_issue_valid & b_issue_ready;
    assign b_word      = B_IN'(8'h40 + b_seq);
    assign b_arr_valid = b_pipe_v | b_force_v;
    assign b_arr_data  = b_force_v ? b_force_d : b_pipe_d;

    // Upstream model: shares aresetn with the DUT, so a reset also discards
    // words in flight and the expectations for them.
    always @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            a_pipe_v <= '0;
            b_pipe_v <= 1'b0;
            a_exp_q.delete();
            b_exp_q.delete();
        end else begin
            a_pipe_v    <= {a_pipe_v[1:0], a_fire};
            a_pipe_d[0] <= a_word;
            a_pipe_d[1] <= a_pipe_d[0];
            a_pipe_d[2] <= a_pipe_d[1];
            if (a_fire) begin
                a_exp_q.push_back(a_word);
                a_seq   <= a_seq + 1;
                a_fires <= a_fires + 1;
            end
            if (a_force_v && a_force_exp) a_exp_q.push_back(a_force_d);

            b_pipe_v <= b_fire;
            b_pipe_d <= b_word;
            if (b_fire) begin
                b_exp_q.push_back(b_word);
                b_seq   <= b_seq + 1;
                b_fires <= b_fires + 1;
            end
            if (b_force_v && b_force_exp) b_exp_q.push_back(b_force_d);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        logic [A_W-1:0] ea;
        logic [B_W-1:0] eb;
        forever begin
            @(negedge clk);
            if (aresetn) begin
                if (a_tvalid && a_tready) begin
                    check("a_pop_has_expect", 64'(a_exp_q.size() != 0), 1);
                    if (a_exp_q.size() != 0) begin
                        ea = a_exp_q.pop_front();
                        check("a_tdata", 64'(a_tdata), 64'(ea[A_IN-1:0]));
                        check("a_tuser", 64'(a_tuser), 64'(ea[A_W-1]));
                    end
                end
                if (b_tvalid && b_tready) begin
                    check("b_pop_has_expect", 64'(b_exp_q.size() != 0), 1);
                    if (b_exp_q.size() != 0) begin
                        eb = b_exp_q.pop_front();
                        check("b_tdata", 64'(b_tdata), 64'(eb));
                        check("b_tuser", 64'(b_tuser), 0);
                    end
                end
            end
        end
    endtask

    task automatic run_stimulus();
        int f0;
        // Reset state
        tick(2);
        check("rst_a_tvalid", a_tvalid, 0);
        check("rst_a_issue_ready", a_issue_ready, 1);
        check("rst_a_occ", a_occ, 0);
        check("rst_a_res", a_res, 0);
        check("rst_a_flags", {a_ovf, a_orph}, 0);
        check("rst_b_tvalid", b_tvalid, 0);
        check("rst_b_issue_ready", b_issue_ready, 1);
        aresetn = 1'b1;

        // 1. Streaming on A: first output word in cycle 4
        a_tready = 1'b1;
        a_issue_valid = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick(1);
            check($sformatf("t1_a_tvalid_c%0d", c), a_tvalid, (c >= 4) ? 1 : 0);
        end
        tick(13);
        a_issue_valid = 1'b0;
        tick(10);
        check("t1_a_occ", a_occ, 0);
        check("t1_a_res", a_res, 0);
        check("t1_a_ovf", a_ovf, 0);
        check("t1_a_orph", a_orph, 0);
        check("t1_a_queue_empty", a_exp_q.size(), 0);

        // 4a. Orphan arrival on A with no credits
        a_tready = 1'b0;
        a_force_d = 33'h1_DEAD_BEEF;
        a_force_exp = 1'b1;
        a_force_v = 1'b1;
        tick(1);
        a_force_v = 1'b0;
        check("t4_orph_set", a_orph, 1);
        check("t4_orph_occ", a_occ, 1);
        check("t4_orph_res", a_res, 0);
        check("t4_orph_tvalid", a_tvalid, 1);
        a_tready = 1'b1;
        tick(1);
        a_tready = 1'b0;
        tick(1);
        check("t4_orph_occ_drained", a_occ, 0);
        check("t4_orph_res_floor", a_res, 0);
        check("t4_orph_sticky", a_orph, 1);

        // 2. Credit limit with tready=0
        f0 = a_fires;
        a_issue_valid = 1'b1;
        tick(12);
        check("t2_fires", a_fires - f0, 4);
        check("t2_issue_ready", a_issue_ready, 0);
        check("t2_occ", a_occ, 4);
        check("t2_res", a_res, 4);
        check("t2_ovf", a_ovf, 0);

        // 3. One tready pulse frees one credit for the following cycle
        a_tready = 1'b1;
        tick(1);
        a_tready = 1'b0;
        check("t3_res_after_pop", a_res, 3);
        check("t3_issue_ready_next", a_issue_ready, 1);
        f0 = a_fires;
        tick(10);
        a_issue_valid = 1'b0;
        check("t3_one_more_fire", a_fires - f0, 1);
        check("t3_issue_ready", a_issue_ready, 0);
        check("t3_occ", a_occ, 4);

        // 4b. Arrival while full, no pop: dropped and flagged
        a_force_d = 33'h0_0BAD_0BAD;
        a_force_exp = 1'b0;
        a_force_v = 1'b1;
        tick(1);
        a_force_v = 1'b0;
        check("t4_ovf_set", a_ovf, 1);
        check("t4_ovf_occ", a_occ, 4);
        check("t4_ovf_res", a_res, 4);

        // B: streaming 20 words through depth 5 wraps the pointers
        f0 = b_fires;
        b_tready = 1'b1;
        b_issue_valid = 1'b1;
        tick(20);
        b_issue_valid = 1'b0;
        tick(6);
        check("b_stream_fires", b_fires - f0, 20);
        check("b_stream_occ", b_occ, 0);
        check("b_stream_res", b_res, 0);

        // 5. B full, then simultaneous arrival and pop
        f0 = b_fires;
        b_tready = 1'b0;
        b_issue_valid = 1'b1;
        tick(8);
        b_issue_valid = 1'b0;
        check("t5_fires", b_fires - f0, 5);
        check("t5_full_occ", b_occ, 5);
        check("t5_issue_ready", b_issue_ready, 0);
        b_tready = 1'b1;
        b_force_d = 8'hEE;
        b_force_exp = 1'b1;
        b_force_v = 1'b1;
        tick(1);
        b_force_v = 1'b0;
        check("t5_occ_same", b_occ, 5);
        check("t5_res", b_res, 4);
        check("t5_no_ovf", b_ovf, 0);
        check("t5_orph", b_orph, 1);
        tick(8);
        check("t5_drain_occ", b_occ, 0);
        check("t5_drain_res", b_res, 0);
        check("t5_queue_empty", b_exp_q.size(), 0);

        // 6. Asynchronous reset mid-stream, checked before any clock edge
        a_tready = 1'b1;
        a_issue_valid = 1'b1;
        b_tready = 1'b1;
        b_issue_valid = 1'b1;
        tick(4);
        #2;
        aresetn = 1'b0;
        #1;
        check("t6_a_tvalid", a_tvalid, 0);
        check("t6_a_occ", a_occ, 0);
        check("t6_a_res", a_res, 0);
        check("t6_a_flags", {a_ovf, a_orph}, 0);
        check("t6_a_issue_ready", a_issue_ready, 1);
        check("t6_b_tvalid", b_tvalid, 0);
        check("t6_b_occ_res", {b_occ, b_res}, 0);
        check("t6_b_flags", {b_ovf, b_orph}, 0);
        check("t6_b_tuser", b_tuser, 0);
        a_issue_valid = 1'b0;
        b_issue_valid = 1'b0;
        tick(2);
        aresetn = 1'b1;
        tick(3);
        check("t6_a_idle", a_tvalid, 0);
        stim_done = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        stim_done = 1'b0;
        aresetn = 1'b0;
        a_issue_valid = 1'b0; a_tready = 1'b0; a_force_v = 1'b0; a_force_exp = 1'b0; a_force_d = '0;
        b_issue_valid = 1'b0; b_tready = 1'b0; b_force_v = 1'b0; b_force_exp = 1'b0; b_force_d = '0;
        fork
            run_stimulus();
            monitor();
            begin
                #100000;
                check("watchdog_stimulus_done", stim_done, 1);
            end
        join_any
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
